// File: rtl/ysyx_24100006_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_lsu
// Load/store unit between the execute stage and the data memory.
// Accepts one request per in_valid/in_ready handshake, drives the memory port
// for exactly one cycle with a word-aligned address, byte mask and
// lane-shifted data, captures one-cycle-latency read data, extends it for the
// selected width and holds the result until out_valid/out_ready completes.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         request handshake
//   in_ren, in_wen              load / store request
//   in_funct3                   000 b, 001 h, 010 w, 100 bu, 101 hu
//   in_addr, in_wdata           byte address, right-aligned store data
//   Mem_Write, Mem_WMask        write strobe, byte-lane mask ([7:4] always 0)
//   waddr, wdata                word-aligned write address, shifted data
//   Mem_Read, raddr             read strobe, word-aligned read address
//   rdata                       read data, valid the cycle after Mem_Read
//   out_valid / out_ready       result handshake
//   out_rdata, out_err          extended load result, misaligned/illegal flag
// ---------------------------------------------------------------------------
module ysyx_24100006_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_ren,
   input  logic        in_wen,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        Mem_Write,
   output logic [7:0]  Mem_WMask,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        Mem_Read,
   output logic [31:0] raddr,
   input  logic [31:0] rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        ren_q, wen_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;
   logic        accept_s;
   logic        mem_write_s, mem_read_s;
   logic [3:0]  wmask_s;

   // Illegal: reserved funct3, misaligned half/word, or load and store together.
   function automatic logic is_illegal(input logic       ren,
                                       input logic       wen,
                                       input logic [2:0] f3,
                                       input logic [1:0] a);
      logic bad_f3;
      logic bad_h;
      logic bad_w;
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      bad_h  = (f3[1:0] == 2'b01) && a[0];
      bad_w  = (f3 == 3'b010) && (a != 2'b00);
      return bad_f3 || bad_h || bad_w || (ren && wen);
   endfunction

   // Store byte mask; only b/h/w are reachable for a legal store.
   function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                             input logic [1:0] k);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = 4'b0001 << k;
         2'b01:   m = 4'b0011 << k;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Shift the addressed lane down to bit 0, then sign/zero-extend.
   function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [31:0] d,
                                               input logic [1:0]  k);
      logic [31:0] sh;
      logic [31:0] r;
      sh = d >> {k, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b010:  r = sh;
         3'b100:  r = {24'h000000, sh[7:0]};
         3'b101:  r = {16'h0000, sh[15:0]};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   assign accept_s = (state_q == IDLE) && in_valid;

   // Next-state, memory strobes and result formation.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      err_d       = err_q;
      mem_write_s = 1'b0;
      mem_read_s  = 1'b0;
      wmask_s     = 4'b0000;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               result_d = 32'h0000_0000;
               if (!in_ren && !in_wen) begin
                  err_d   = 1'b0;
                  state_d = RESP;
               end else if (is_illegal(in_ren, in_wen, in_funct3, in_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (wen_q) begin
               mem_write_s = 1'b1;
               wmask_s     = store_mask(funct3_q, addr_q[1:0]);
               state_d     = RESP;
            end else if (ren_q) begin
               mem_read_s = 1'b1;
               state_d    = DATA;
            end else begin
               state_d = RESP;
            end
         end
         DATA: begin
            result_d = load_extend(funct3_q, rdata, addr_q[1:0]);
            state_d  = RESP;
         end
         RESP: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= 32'h0000_0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   // Request capture on the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0000_0000;
         wdata_q  <= 32'h0000_0000;
      end else if (accept_s) begin
         ren_q    <= in_ren;
         wen_q    <= in_wen;
         funct3_q <= in_funct3;
         addr_q   <= in_addr;
         wdata_q  <= in_wdata;
      end else begin
         ren_q    <= ren_q;
         wen_q    <= wen_q;
         funct3_q <= funct3_q;
         addr_q   <= addr_q;
         wdata_q  <= wdata_q;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == RESP);
   assign out_rdata = result_q;
   assign out_err   = err_q;
   assign Mem_Write = mem_write_s;
   assign Mem_Read  = mem_read_s;
   assign Mem_WMask = {4'b0000, wmask_s};
   assign waddr     = {addr_q[31:2], 2'b00};
   assign raddr     = {addr_q[31:2], 2'b00};
   assign wdata     = wdata_q << {addr_q[1:0], 3'b000};

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
module tb_ysyx_24100006_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_ren, in_wen;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic        Mem_Write, Mem_Read;
   logic [7:0]  Mem_WMask;
   logic [31:0] waddr, wdata, raddr, rdata;
   logic        out_valid, out_ready, out_err;
   logic [31:0] out_rdata;

   int          checks   = 0;
   int          failures = 0;

   logic [31:0] mem_word;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   logic [31:0] last_waddr, last_wdata, last_raddr;
   logic [7:0]  last_wmask;

   always #5 clk = ~clk;

   ysyx_24100006_lsu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ren    (in_ren),
      .in_wen    (in_wen),
      .in_funct3 (in_funct3),
      .in_addr   (in_addr),
      .in_wdata  (in_wdata),
      .Mem_Write (Mem_Write),
      .Mem_WMask (Mem_WMask),
      .waddr     (waddr),
      .wdata     (wdata),
      .Mem_Read  (Mem_Read),
      .raddr     (raddr),
      .rdata     (rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rdata (out_rdata),
      .out_err   (out_err)
   );

   // One-word memory with one-cycle read latency.
   always @(posedge clk) begin
      if (Mem_Read) rdata <= mem_word;
   end

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (Mem_Write) begin
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= waddr;
         last_wdata <= wdata;
         last_wmask <= Mem_WMask;
      end
      if (Mem_Read) begin
         rd_cnt     <= rd_cnt + 1;
         last_raddr <= raddr;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request, check latency, strobes, result and handshake.
   task automatic run_req(input string tag, input logic ren, input logic wen,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_wr, input int exp_rd,
                          input logic [7:0] exp_mask, input logic [31:0] exp_wdata,
                          input int stall);
      int wr0;
      int rd0;
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      in_valid = 1'b1; in_ren = ren; in_wen = wen;
      in_funct3 = f3; in_addr = addr; in_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
      for (int i = 1; i <= lat; i++) begin
         if (i > 1) @(negedge clk);
         check_eq({tag, "_out_valid_lat"}, {31'd0, out_valid}, (i == lat) ? 32'd1 : 32'd0);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check_eq({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
         check_eq({tag, "_stall_rdata"}, out_rdata, exp_rdata);
         check_eq({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      check_eq({tag, "_rdata"}, out_rdata, exp_rdata);
      check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
      check_eq({tag, "_wr_cnt"}, 32'(wr_cnt - wr0), 32'(exp_wr));
      check_eq({tag, "_rd_cnt"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      if (exp_wr != 0) begin
         check_eq({tag, "_waddr"}, last_waddr, exp_addr);
         check_eq({tag, "_wmask"}, {24'd0, last_wmask}, {24'd0, exp_mask});
         check_eq({tag, "_wdata"}, last_wdata, exp_wdata);
      end
      if (exp_rd != 0) begin
         check_eq({tag, "_raddr"}, last_raddr, exp_addr);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
      in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0;
      out_ready = 1'b0; rdata = 32'd0; mem_word = 32'h8001_FF7F;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_rdata", out_rdata, 32'd0);
      check_eq("rst_waddr", waddr, 32'd0);
      check_eq("rst_wdata", wdata, 32'd0);
      check_eq("rst_strobes", {22'd0, Mem_Write, Mem_Read, Mem_WMask}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Stores
      run_req("sw",  1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 1, 0, 8'h0F, 32'hDEAD_BEEF, 0);
      run_req("sb3", 1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 2, 32'd0, 1'b0, 1, 0, 8'h08, 32'hA500_0000, 0);
      run_req("sh2", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_BEEF, 2, 32'd0, 1'b0, 1, 0, 8'h0C, 32'hBEEF_0000, 0);
      run_req("sb1", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_0077, 2, 32'd0, 1'b0, 1, 0, 8'h02, 32'h0000_7700, 0);

      // Loads from word 0x8001FF7F
      run_req("lb3",  1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 3, 32'hFFFF_FF80, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lbu3", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'd0, 3, 32'h0000_0080, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lh2",  1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0, 3, 32'hFFFF_8001, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lhu0", 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'd0, 3, 32'h0000_FF7F, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lw",   1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'd0, 3, 32'h8001_FF7F, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lb1",  1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'd0, 3, 32'hFFFF_FFFF, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lh0",  1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'd0, 3, 32'hFFFF_FF7F, 1'b0, 0, 1, 8'h00, 32'd0, 0);
      run_req("lbu0", 1'b1, 1'b0, 3'b100, 32'h8000_0000, 32'd0, 3, 32'h0000_007F, 1'b0, 0, 1, 8'h00, 32'd0, 0);

      // Illegal and no-op requests
      run_req("lw_mis", 1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'd0, 1, 32'd0, 1'b1, 0, 0, 8'h00, 32'd0, 0);
      run_req("lh_mis", 1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'd0, 1, 32'd0, 1'b1, 0, 0, 8'h00, 32'd0, 0);
      run_req("sw_mis", 1'b0, 1'b1, 3'b010, 32'h8000_0001, 32'hFFFF_FFFF, 1, 32'd0, 1'b1, 0, 0, 8'h00, 32'd0, 0);
      run_req("f3_011", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'd0, 1, 32'd0, 1'b1, 0, 0, 8'h00, 32'd0, 0);
      run_req("f3_110", 1'b0, 1'b1, 3'b110, 32'h8000_0000, 32'd0, 1, 32'd0, 1'b1, 0, 0, 8'h00, 32'd0, 0);
      run_req("rw_both", 1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'd0, 1, 32'd0, 1'b1, 0, 0, 8'h00, 32'd0, 0);
      run_req("noop", 1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'd0, 1, 32'd0, 1'b0, 0, 0, 8'h00, 32'd0, 0);

      // Stalled response
      mem_word = 32'h1234_5678;
      run_req("stall_lw", 1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'd0, 3, 32'h1234_5678, 1'b0, 0, 1, 8'h00, 32'd0, 5);
      run_req("after_stall", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'd0, 3, 32'h0000_1234, 1'b0, 0, 1, 8'h00, 32'd0, 0);

      // Reset during ISSUE of a store
      in_valid = 1'b1; in_ren = 1'b0; in_wen = 1'b1;
      in_funct3 = 3'b010; in_addr = 32'h8000_0010; in_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_wen = 1'b0;
      check_eq("rstmid_issue_wr", {31'd0, Mem_Write}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rstmid_wr_drop", {31'd0, Mem_Write}, 32'd0);
      check_eq("rstmid_mask", {24'd0, Mem_WMask}, 32'd0);
      check_eq("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rstmid_waddr", waddr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rstrel_strobes", {30'd0, Mem_Write, Mem_Read}, 32'd0);
      check_eq("rstrel_out_valid", {31'd0, out_valid}, 32'd0);
      mem_word = 32'hA5A5_0F0F;
      run_req("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 3, 32'hA5A5_0F0F, 1'b0, 0, 1, 8'h00, 32'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_24100006_lsu.md
# ysyx_24100006_lsu

Load/store unit between the execute stage and the DPI-C data memory. It accepts one memory request per valid/ready handshake and drives the memory's write/read port with word-aligned address, byte mask and lane-shifted data. It captures the memory's one-cycle-latency read data and sign- or zero-extends it for the selected load width. The result is then held for write-back under a second valid/ready handshake.

## Interface
Parameters:
- none (data and address width fixed at 32)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid from execute stage
- in_ready  output  1  LSU can accept a request
- in_ren  input  1  request is a load
- in_wen  input  1  request is a store
- in_funct3  input  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- in_addr  input  32  byte address
- in_wdata  input  32  store data, right-aligned
- Mem_Write  output  1  memory write strobe
- Mem_WMask  output  8  byte-lane mask; bits [3:0] used, [7:4] always 0
- waddr  output  32  write address, word-aligned
- wdata  output  32  write data, lane-shifted
- Mem_Read  output  1  memory read strobe
- raddr  output  32  read address, word-aligned
- rdata  input  32  memory read data, valid the cycle after Mem_Read is sampled
- out_valid  output  1  result valid to write-back
- out_ready  input  1  write-back accepts result
- out_rdata  output  32  extended load result; 0 for stores and errors
- out_err  output  1  misaligned or illegal access

## Operation
- FSM states: IDLE, ISSUE, DATA, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, register ren, wen, funct3, addr and wdata.
  - Legal load or store -> ISSUE.
  - Illegal request -> RESP with out_err=1.
  - ren=wen=0 -> RESP with out_err=0 and out_rdata=0.
- Illegal request, any of:
  - funct3 in {011, 110, 111};
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - ren and wen both set.
  - No memory strobe is ever issued for an illegal request.
- ISSUE: drive memory combinationally from the registered request for exactly one cycle.
  - Store: Mem_Write=1, then -> RESP.
  - Load: Mem_Read=1, then -> DATA.
- Address: waddr = raddr = {addr[31:2], 2'b00}.
- Byte lane k = addr[1:0].
  - Store mask: b = 0001<<k, h = 0011<<k, w = 1111.
  - wdata = in_wdata << (8·k).
- DATA: capture rdata and form the result, then -> RESP.
  - shifted = rdata >> (8·k).
  - b: sign-extend shifted[7:0]; bu: zero-extend [7:0].
  - h: sign-extend [15:0]; hu: zero-extend [15:0].
  - w: shifted unchanged.
- RESP: out_valid=1; out_rdata and out_err held stable until out_ready=1, then -> IDLE.
- Outside ISSUE: Mem_Write=0, Mem_Read=0, Mem_WMask=0. waddr, raddr and wdata may hold the registered values.
- Reset (async, any state): state -> IDLE.
  - in_ready is 1 after reset.
  - All other outputs are 0: out_valid, out_err, out_rdata, Mem_Write, Mem_Read, Mem_WMask, waddr, raddr, wdata.
  - A request in flight is discarded; no strobe is asserted in the cycle after reset release.

## Timing
- Request accepted on edge E0 (in_valid & in_ready).
- Store: ISSUE in cycle after E0, memory writes at E1, out_valid from E1.
- Load: ISSUE after E0, memory reads at E1, DATA after E1 (rdata valid), result registered at E2, out_valid from E2.
- Illegal or no-op request: out_valid from E0+1 edge (RESP directly).
- out_valid falls on the edge where out_ready=1 is sampled. in_ready is 1 in the following cycle; no request is accepted in the same cycle as the response handshake.
- Throughput: one request per ≥3 cycles (store), ≥4 cycles (load).
- out_ready held 0 stalls in RESP indefinitely. Memory is not touched again while stalled.

## Test plan
- sw addr=0x80000004 wdata=0xDEADBEEF:
  - one-cycle Mem_Write, waddr=0x80000004, Mem_WMask=0x0F, wdata=0xDEADBEEF;
  - out_valid 2 edges after accept, out_err=0.
- sb addr=0x80000003 wdata=0x000000A5: Mem_WMask=0x08, wdata=0xA5000000, waddr=0x80000000.
- Memory word 0x80000000 = 0x8001FF7F:
  - lb@+3 -> 0xFFFFFF80;
  - lbu@+3 -> 0x00000080;
  - lh@+2 -> 0xFFFF8001;
  - lhu@+0 -> 0x0000FF7F;
  - lw -> 0x8001FF7F;
  - each load's out_valid 3 edges after accept.
- lw addr=0x80000002 and lh addr=0x80000001: no Mem_Read or Mem_Write ever asserted; out_err=1, out_rdata=0 one edge after accept.
- Load accepted, out_ready held 0 for 5 cycles: out_valid and out_rdata stable, in_ready=0, no further strobes; release -> IDLE, next request accepted.
- Reset:
  - Assert rst_n=0 during ISSUE of a store: Mem_Write drops immediately, out_valid=0, in_ready=1 after release.
  - A fresh lw then completes correctly.
